gpio_bank_bus: RTL
==================

# gpio_bank_bus

Parametrised memory-mapped GPIO bank slave on the CPU native bus (`mem_valid`/`mem_ready`), replacing hand-decoded LED and button registers in the SoC top level. It provides `NUM_CH` channels of `WIDTH`-bit outputs and synchronised, optionally debounced inputs. Each channel has falling-edge capture with write-1-to-clear, and a combined interrupt output. It sits beside the RAM and UART decode, and its `sel` output feeds the top-level `mem_ready`/`mem_rdata` mux.

## Interface
- `NUM_CH`, 2, number of channels (1..16)
- `WIDTH`, 8, bits per channel (1..32)
- `BASE_ADDR`, 32'h0300_0000, window base; 16-byte aligned
- `DEBOUNCE_CYCLES`, 24000, prescaler period in clocks (≥2); used only with `GPIO_DEBOUNCE_EN`
- `clk`  in  1  bus/core clock
- `resetn`  in  1  synchronous, active-low reset
- `mem_valid`  in  1  bus request
- `mem_addr`  in  32  byte address
- `mem_wdata`  in  32  write data
- `mem_wstrb`  in  4  byte write strobes; 0 = read
- `sel`  out  1  combinational address hit; drives the top-level mux select
- `mem_ready`  out  1  one-cycle completion pulse
- `mem_rdata`  out  32  read data, valid while `mem_ready`=1
- `pin_in`  in  NUM_CH*WIDTH  raw inputs, active-low, pulled-up; channel c at [c*WIDTH +: WIDTH]
- `pin_out`  out  NUM_CH*WIDTH  OUT registers
- `irq`  out  1  OR over channels of (EDGE & IRQ_EN)

## Operation
- Hit condition: `sel` = `mem_valid` && BASE_ADDR ≤ `mem_addr` < BASE_ADDR + NUM_CH*16. `addr[1:0]` ignored.
- Channel index: `(addr-BASE)[7:4]`. Register offset: `addr[3:2]`.
- Channel registers:
  - +0 OUT: RW.
  - +4 IN: RO, filtered input.
  - +8 EDGE: W1C.
  - +C IRQ_EN: RW.
- Fields occupy bits [WIDTH-1:0]. Upper read bits are 0.
- Writes honour byte strobes: lane k updates bits [8k+7:8k] ∩ [WIDTH-1:0]. Writes to IN are ignored.
- Input path:
  - Each `pin_in` bit passes through a 2-flop synchroniser, giving `sync`.
  - Without debounce: `filt` = `sync`.
  - With debounce: a shared prescaler counts 0..DEBOUNCE_CYCLES-1 and pulses `tick` at wrap. On `tick`, each bit does: if `sync` == `samp`, then `filt` ← `sync`; then `samp` ← `sync`.
- Edge capture:
  - A 1→0 transition of `filt` (registered previous vs current) sets the EDGE bit.
  - Writing 1 clears an EDGE bit.
  - If a set and a clear occur in the same cycle, set wins.
- `irq` is registered: `irq` ← |(EDGE & IRQ_EN) over all channels.
- Bus FSM states: IDLE and ACK.
  - IDLE→ACK when `sel`. Register `mem_ready`=1 and load `mem_rdata`.
  - ACK→IDLE unconditionally, with `mem_ready`=0.
- The write is applied on the IDLE→ACK clock edge.
- Hits to an unmapped channel (index ≥ NUM_CH cannot occur by hit rule) or to the IN register on write still complete with `mem_ready`.

## Timing
- Reset values:
  - `mem_ready`=0, `mem_rdata`=0, OUT=0, `pin_out`=0, EDGE=0, IRQ_EN=0, `irq`=0.
  - Synchroniser, `samp`, and `filt` reset to all-ones, so there is no spurious edge out of reset.
  - Prescaler resets to 0.
- Access latency: `mem_ready` rises 1 clock after `sel` is first seen, and lasts exactly 1 clock.
- A `sel` still high in the ACK cycle is ignored. A back-to-back request therefore completes at the earliest 2 clocks after the previous one.
- `pin_out` changes on the same edge that asserts `mem_ready`.
- Read data is the register state before that edge's write.
- Input to IN latency:
  - Without debounce: 2 clocks.
  - With debounce: the new level must be seen at 2 consecutive ticks. Latency is 2 + (1..2)×DEBOUNCE_CYCLES clocks.
  - Glitches shorter than one tick period are rejected.
- EDGE sets 1 clock after `filt` falls. `irq` follows 1 clock later.
- If `resetn`=0 during ACK, the next state is IDLE with `mem_ready`=0. A write sampled on a reset edge is discarded.
- The prescaler runs continuously, independent of bus traffic.

## Configuration
- `GPIO_DEBOUNCE_EN` defined: the prescaler, `samp` registers, and two-sample agreement filter are built.
- `GPIO_DEBOUNCE_EN` undefined: `filt` = `sync`, no prescaler logic, and `DEBOUNCE_CYCLES` is unused. All other behaviour is identical.

## Test plan
- Reset with `pin_in` all ones:
  - `mem_ready`=0 and `irq`=0.
  - Read BASE+4 → 0x0000_00FF.
  - Read BASE+8 → 0.
- Write 0xA5 to BASE+0 with wstrb=4'b0001:
  - `mem_ready` pulses 1 clock after `mem_valid`.
  - `pin_out[7:0]`=0xA5.
  - Read back → 0x0000_00A5.
  - Write with wstrb=4'b0010 leaves it unchanged.
- Write 0x08 to IRQ_EN of ch1 (BASE+0x1C), then drive `pin_in[11]` low:
  - Undebounced: EDGE ch1 (BASE+0x18) reads 0x08 after 3 clocks, and `irq`=1 one clock later.
  - Write 0x08 to BASE+0x18 → EDGE=0, `irq`=0.
- With `GPIO_DEBOUNCE_EN`, DEBOUNCE_CYCLES=4:
  - A low pulse of 3 clocks on `pin_in[0]` → IN bit 0 stays 1 and EDGE stays 0.
  - Holding it low for 12 clocks → IN bit 0 = 0 within 2+8 clocks.
- Simultaneous W1C write to EDGE bit 0 and a new falling edge on the same bit in the same clock → EDGE bit 0 remains 1.
- Hold `mem_valid` high continuously:
  - `mem_ready` pattern is 0,1,0,1.
  - An address outside the window (BASE+NUM_CH*16) gives `sel`=0 and no `mem_ready`.
  - `resetn` low in the ACK cycle → `mem_ready`=0 next clock.

Source files
------------

// File: rtl/gpio_bank_bus.sv
// Memory-mapped GPIO bank on the native CPU bus: per-channel OUT/IN/EDGE/IRQ_EN registers.
// Define GPIO_DEBOUNCE_EN to build the prescaled two-sample input debounce filter.
module gpio_bank_bus #(
    parameter int          NUM_CH          = 2,
    parameter int          WIDTH           = 8,
    parameter logic [31:0] BASE_ADDR       = 32'h0300_0000,
    parameter int          DEBOUNCE_CYCLES = 24000
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    mem_valid,
    input  logic [31:0]             mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_wstrb,
    output logic                    sel,
    output logic                    mem_ready,
    output logic [31:0]             mem_rdata,
    input  logic [NUM_CH*WIDTH-1:0] pin_in,
    output logic [NUM_CH*WIDTH-1:0] pin_out,
    output logic                    irq
);

    localparam int          NBITS  = NUM_CH * WIDTH;
    localparam logic [31:0] WINDOW = 32'(NUM_CH * 16);

    if (NUM_CH < 1 || NUM_CH > 16 || WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2) begin : g_bad_params
        $error("gpio_bank_bus: parameter out of range");
    end

    typedef enum logic {IDLE, ACK} state_t;

    state_t                         state_q, state_d;
    logic [31:0]                    offset;
    logic [3:0]                     ch_idx;
    logic [1:0]                     reg_idx;
    logic                           access, wr_en;
    logic [WIDTH-1:0]               wr_mask, wr_data;
    logic [31:0]                    rd_mux, rdata_q;
    logic [NUM_CH-1:0][WIDTH-1:0]   out_q, edge_q, edge_d, irq_en_q, filt_ch, fall_ch;
    logic [NBITS-1:0]               sync1_q, sync_q, filt, filt_prev_q;
    logic                           irq_q;
    logic                           unused_wdata;

    assign offset       = mem_addr - BASE_ADDR;
    assign sel          = mem_valid && (mem_addr >= BASE_ADDR) && (offset < WINDOW);
    assign ch_idx       = offset[7:4];
    assign reg_idx      = offset[3:2];
    assign wr_data      = mem_wdata[WIDTH-1:0];
    assign unused_wdata = ^mem_wdata;

    always_comb begin
        for (int b = 0; b < WIDTH; b++) wr_mask[b] = mem_wstrb[b / 8];
    end

    // ---- bus FSM: state register / next state / outputs
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (state_q == ACK);
        access    = (state_q == IDLE) && sel;
        wr_en     = access && (mem_wstrb != 4'b0000);
    end

    // ---- input synchroniser and optional debounce
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (!resetn) begin
            sync1_q     <= '1;
            sync_q      <= '1;
            filt_prev_q <= '1;
        end else begin
            sync1_q     <= pin_in;
            sync_q      <= sync1_q;
            filt_prev_q <= filt;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0]    presc_q;
    logic             tick;
    logic [NBITS-1:0] samp_q, filt_q, agree;

    assign tick  = (presc_q == CW'(DEBOUNCE_CYCLES - 1));
    assign agree = ~(sync_q ^ samp_q);

    // A bit only moves once the same level has been seen at two consecutive ticks.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc_q <= '0;
            samp_q  <= '1;
            filt_q  <= '1;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                filt_q <= (agree & sync_q) | (~agree & filt_q);
                samp_q <= sync_q;
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync_q;
`endif

    assign filt_ch = filt;
    assign fall_ch = filt_prev_q & ~filt;

    // Edge set wins over a simultaneous write-1-to-clear.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && ch_idx == 4'(c) && reg_idx == 2'd2)
                edge_d[c] = (edge_q[c] & ~(wr_data & wr_mask)) | fall_ch[c];
            else
                edge_d[c] = edge_q[c] | fall_ch[c];
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == 4'(c)) begin
                case (reg_idx)
                    2'd0:    rd_mux[WIDTH-1:0] = out_q[c];
                    2'd1:    rd_mux[WIDTH-1:0] = filt_ch[c];
                    2'd2:    rd_mux[WIDTH-1:0] = edge_q[c];
                    default: rd_mux[WIDTH-1:0] = irq_en_q[c];
                endcase
            end
        end
    end

    // ---- register file
    always_ff @(posedge clk) begin
        // NOTE: the register arrays are few flops, not RAM, so they take an explicit reset value.
        if (!resetn) begin
            out_q    <= '0;
            edge_q   <= '0;
            irq_en_q <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (access) rdata_q <= rd_mux;
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_en && ch_idx == 4'(c)) begin
                    if (reg_idx == 2'd0) out_q[c]    <= (out_q[c] & ~wr_mask) | (wr_data & wr_mask);
                    if (reg_idx == 2'd3) irq_en_q[c] <= (irq_en_q[c] & ~wr_mask) | (wr_data & wr_mask);
                end
            end
            edge_q <= edge_d;
            irq_q  <= |(edge_q & irq_en_q);
        end
    end

    assign mem_rdata = rdata_q;
    assign pin_out   = out_q;
    assign irq       = irq_q;

endmodule
